// File: rtl/timer_irq_periph.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_periph
// Brief    : Memory-mapped reloading timer with level IRQ, prescaler and a
//            free-running read-only cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module timer_irq_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    localparam logic [31:0] c_ADDR_TH      = BASE_ADDR;
    localparam logic [31:0] c_ADDR_TL      = BASE_ADDR + 32'h4;
    localparam logic [31:0] c_ADDR_TCON    = BASE_ADDR + 32'h8;
    localparam logic [31:0] c_ADDR_SYSTICK = BASE_ADDR + 32'hC;
    localparam logic [15:0] c_PCNT_MAX     = 16'(PRESCALE - 1);
    localparam logic [31:0] c_TL_MAX       = 32'hFFFF_FFFF;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic        r_en;
    logic        r_ie;
    logic        r_st;
    logic [31:0] r_systick;
    logic [15:0] r_pcnt;

    logic        w_hit_th;
    logic        w_hit_tl;
    logic        w_hit_tcon;
    logic        w_hit_systick;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_ovf;
    logic        w_ovf_set;
    logic [31:0] w_rdata;

    assign w_hit_th      = (Addr == c_ADDR_TH);
    assign w_hit_tl      = (Addr == c_ADDR_TL);
    assign w_hit_tcon    = (Addr == c_ADDR_TCON);
    assign w_hit_systick = (Addr == c_ADDR_SYSTICK);

    assign w_wr_th   = MemWr && w_hit_th;
    assign w_wr_tl   = MemWr && w_hit_tl;
    assign w_wr_tcon = MemWr && w_hit_tcon;

    // Tick and overflow are qualified with the pre-edge EN/IE, so a TCON
    // write never changes what happens on its own edge.
    assign w_tick    = r_en && (r_pcnt == c_PCNT_MAX);
    assign w_ovf     = w_tick && (r_tl == c_TL_MAX);
    assign w_ovf_set = w_ovf && r_ie;

    assign IRQ = r_ie && r_st;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (r_en) begin
            if (r_pcnt == c_PCNT_MAX) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_th <= '0;
        end else if (w_wr_th) begin
            r_th <= WriteData;
        end
    end

    // A bus write to TL overrides the increment/reload of the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tl <= '0;
        end else if (w_wr_tl) begin
            r_tl <= WriteData;
        end else if (w_ovf) begin
            r_tl <= r_th;
        end else if (w_tick) begin
            r_tl <= r_tl + 32'd1;
        end
    end

    // ST from a coincident overflow is OR-ed in so a clear never loses it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en <= 1'b0;
            r_ie <= 1'b0;
            r_st <= 1'b0;
        end else if (w_wr_tcon) begin
            r_en <= WriteData[0];
            r_ie <= WriteData[1];
            r_st <= WriteData[2] | w_ovf_set;
        end else if (w_ovf_set) begin
            r_st <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (MemRd) begin
            if (w_hit_th) begin
                w_rdata = r_th;
            end else if (w_hit_tl) begin
                w_rdata = r_tl;
            end else if (w_hit_tcon) begin
                w_rdata = {29'd0, r_st, r_ie, r_en};
            end else if (w_hit_systick) begin
                w_rdata = r_systick;
            end
        end
    end

    assign ReadData = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_irq_periph
// Brief    : Directed, table-driven self-checking bench for timer_irq_periph.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_irq_periph;

    localparam logic [31:0] c_BASE = 32'h4000_0000;
    localparam logic [31:0] c_TH   = c_BASE;
    localparam logic [31:0] c_TL   = c_BASE + 32'h4;
    localparam logic [31:0] c_TCON = c_BASE + 32'h8;
    localparam logic [31:0] c_SYS  = c_BASE + 32'hC;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd1;
    logic [31:0] rd4;
    logic        irq1;
    logic        irq4;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] st_model = '0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    timer_irq_periph #(.BASE_ADDR(c_BASE), .PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .MemRd(mem_rd), .MemWr(mem_wr),
        .Addr(addr), .WriteData(wdata), .ReadData(rd1), .IRQ(irq1)
    );

    timer_irq_periph #(.BASE_ADDR(c_BASE), .PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(reset), .MemRd(mem_rd), .MemWr(mem_wr),
        .Addr(addr), .WriteData(wdata), .ReadData(rd4), .IRQ(irq4)
    );

    // One call per clock cycle; outputs are stable for checking on return.
    task automatic step(input logic s_rst, input logic s_rd, input logic s_wr,
                        input logic [31:0] s_addr, input logic [31:0] s_wd);
        @(negedge clk);
        st_model = reset ? 32'd0 : st_model + 32'd1;
        reset  = s_rst;
        mem_rd = s_rd;
        mem_wr = s_wr;
        addr   = s_addr;
        wdata  = s_wd;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic s_rst, logic s_rd, logic s_wr, logic [31:0] s_addr,
                                logic [31:0] s_wd, logic s_chk, logic [31:0] e_rd, logic e_irq);
        vec_t v;
        v.rst = s_rst; v.rd = s_rd; v.wr = s_wr; v.addr = s_addr; v.wd = s_wd;
        v.chk = s_chk; v.exp_rd = e_rd; v.exp_irq = e_irq;
        return v;
    endfunction

    initial begin
        // Reset, basic overflow, ISR clear and clear coincident with overflow.
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, c_TH,   32'h0, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, c_TL,   32'h0, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, c_TCON, 32'h0, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, c_SYS,  32'h0, 1, 32'h3, 0));
        vecs.push_back(mk(0, 0, 1, c_TH,   32'hFFFF_FFFC, 1, 32'h0, 0));
        vecs.push_back(mk(0, 0, 1, c_TL,   32'hFFFF_FFFE, 1, 32'h0, 0));
        vecs.push_back(mk(0, 0, 1, c_TCON, 32'h3, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, c_TL,   32'h0, 1, 32'hFFFF_FFFE, 0));
        vecs.push_back(mk(0, 1, 0, c_TL,   32'h0, 1, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(0, 1, 0, c_TL,   32'h0, 1, 32'hFFFF_FFFC, 1));
        vecs.push_back(mk(0, 1, 0, c_TCON, 32'h0, 1, 32'h7, 1));
        vecs.push_back(mk(0, 0, 1, c_TCON, 32'h3, 1, 32'h0, 1));
        vecs.push_back(mk(0, 1, 1, c_TCON, 32'h3, 1, 32'h3, 0));
        vecs.push_back(mk(0, 1, 0, c_TCON, 32'h0, 1, 32'h7, 1));
        vecs.push_back(mk(0, 1, 0, c_TL,   32'h0, 1, 32'hFFFF_FFFD, 1));
        vecs.push_back(mk(0, 0, 1, c_TCON, 32'h0, 1, 32'h0, 1));
        vecs.push_back(mk(0, 1, 0, c_TL,   32'h0, 1, 32'hFFFF_FFFF, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rd", i), rd1, vecs[i].exp_rd);
                check($sformatf("vec%0d_irq", i), {31'd0, irq1}, {31'd0, vecs[i].exp_irq});
            end
        end

        // Timer disabled: TL frozen.
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, c_TL, 32'h0);
            check($sformatf("frozen%0d", k), rd1, 32'hFFFF_FFFF);
        end

        // SYSTICK ignores writes; unmapped window offset reads 0.
        step(0, 0, 1, c_SYS, 32'h1234_5678);
        step(0, 1, 0, c_SYS, 32'h0);
        check("systick_wr_ignored", rd1, st_model);
        step(0, 1, 0, c_BASE + 32'h10, 32'h0);
        check("unmapped_rd", rd1, 32'h0);

        // Overflow with IE=0 reloads TL, ST and IRQ stay low.
        step(0, 0, 1, c_TH, 32'h0000_0100);
        step(0, 0, 1, c_TL, 32'hFFFF_FFFE);
        step(0, 0, 1, c_TCON, 32'h1);
        step(0, 1, 0, c_TL, 32'h0);
        check("ie0_pre1", rd1, 32'hFFFF_FFFE);
        step(0, 1, 0, c_TL, 32'h0);
        check("ie0_pre2", rd1, 32'hFFFF_FFFF);
        step(0, 1, 0, c_TL, 32'h0);
        check("ie0_reload", rd1, 32'h0000_0100);
        check("ie0_irq", {31'd0, irq1}, 32'h0);
        step(0, 1, 0, c_TCON, 32'h0);
        check("ie0_tcon", rd1, 32'h1);

        // TL write coincident with a tick wins over the increment.
        step(0, 0, 1, c_TL, 32'h55);
        step(0, 1, 0, c_TL, 32'h0);
        check("tl_wr_tick", rd1, 32'h55);
        step(0, 1, 0, c_TL, 32'h0);
        check("tl_after_wr", rd1, 32'h56);

        // Reset beats a coincident bus write.
        step(1, 0, 1, c_TH, 32'h0000_0ABC);
        step(1, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, c_TH, 32'h0);
        check("reset_beats_wr", rd1, 32'h0);
        check("reset_irq", {31'd0, irq1}, 32'h0);

        // Prescaler of 4 on the second instance.
        step(0, 0, 1, c_TCON, 32'h1);
        for (int k = 0; k < 12; k++) idle();
        step(0, 1, 0, c_TL, 32'h0);
        check("psc_12cyc", rd4, 32'h3);
        step(0, 0, 1, c_TCON, 32'h0);
        for (int k = 0; k < 5; k++) idle();
        step(0, 1, 0, c_TL, 32'h0);
        check("psc_held", rd4, 32'h3);
        step(0, 0, 1, c_TCON, 32'h1);
        step(0, 1, 0, c_TL, 32'h0);
        check("psc_resume1", rd4, 32'h3);
        step(0, 1, 0, c_TL, 32'h0);
        check("psc_resume2", rd4, 32'h3);
        step(0, 1, 0, c_TL, 32'h0);
        check("psc_resume3", rd4, 32'h4);
        check("psc_irq", {31'd0, irq4}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_irq_periph.md
Name: timer_irq_periph

Overview:
- Memory-mapped programmable timer on the data bus, alongside data memory, in the single-cycle MIPS core.
- Produces the IRQ input consumed by the instruction decoder/control unit. The decoder masks IRQ with PC31 and vectors to the interrupt handler.
- Software sets the reload value, enables counting and interrupts, and clears the pending status from the handler.
- Also exposes a free-running, read-only system cycle counter.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the 4-word register window.
- PRESCALE, 1, clock cycles per TL increment; legal range 1..65535.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRd  in  1  bus read strobe, same cycle as Addr.
- MemWr  in  1  bus write strobe, same cycle as Addr/WriteData.
- Addr  in  32  byte address, word aligned.
- WriteData  in  32  write data.
- ReadData  out  32  combinational read data.
- IRQ  out  1  interrupt request to control unit, level.

Behaviour:
- Register map (full 32-bit address match, offset from BASE_ADDR):
  - +0x0 TH: reload value, R/W.
  - +0x4 TL: counter, R/W.
  - +0x8 TCON: bits[2:0], upper bits read 0, R/W.
    - bit0 EN: count enable.
    - bit1 IE: interrupt enable.
    - bit2 ST: interrupt status.
  - +0xC SYSTICK: free-running cycle count, read-only; writes ignored.
- Reset (reset=1 at clock edge): TH=0, TL=0, TCON=0, SYSTICK=0, prescale counter=0. IRQ=0 the cycle after.
- ReadData:
  - MemRd=1 and Addr hits a register: that register's current (pre-edge) value, same cycle.
  - Otherwise 32'h0, including unmapped offsets inside the window.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 while EN=1, wrapping to 0.
  - A tick occurs in any cycle where EN=1 and pcnt==PRESCALE-1.
  - EN=0 holds pcnt; it does not clear it.
  - PRESCALE=1 gives a tick every cycle while EN=1.
- Tick with TL!=32'hFFFF_FFFF: TL <= TL+1.
- Tick with TL==32'hFFFF_FFFF (overflow): TL <= TH (not 0). If IE=1, ST <= 1.
- Overflow with IE=0: TL still reloads; ST unchanged.
- IRQ = IE & ST, combinational from registers.
  - Asserts the cycle after the overflow edge.
  - Stays high until software clears ST or IE.
- Bus write priority (MemWr=1, address hit):
  - TH write: TH <= WriteData. A reload in the same cycle uses the old TH.
  - TL write: TL <= WriteData; suppresses that cycle's increment/reload. ST set by a coincident overflow still occurs.
  - TCON write: EN,IE <= WriteData[1:0]. ST <= WriteData[2] | ovf_set, where ovf_set is an overflow this cycle computed with the old EN/IE. A pending interrupt is never lost to a clear.
  - Tick qualification in a TCON-write cycle uses the old EN.
- SYSTICK increments every cycle not in reset; wraps from FFFF_FFFF to 0.
- MemRd and MemWr together: the write takes effect at the edge; ReadData shows the pre-write value.
- reset mid-count wins over everything, including a bus write in the same cycle.

Test Plan:
- Reset check: reset=1 for 2 cycles, then MemRd TH/TL/TCON/SYSTICK -> reads 0,0,0, small count (1 after first post-reset edge); IRQ=0.
- Basic overflow, PRESCALE=1:
  - Write TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3.
  - TL reads FFFF_FFFF after 1 tick, then FFFF_FFFC after the next.
  - IRQ=1 exactly one cycle after the overflow edge; TCON reads 7.
- Clear in ISR: with IRQ=1, write TCON=3 -> IRQ=0 next cycle, counting continues. Write TCON=0 -> TL frozen across 10 cycles.
- Simultaneous clear and overflow: write TCON=3 in the same cycle TL==FFFF_FFFF and EN=IE=1 -> ST stays 1, IRQ stays 1, TL=TH.
- Prescaler, PRESCALE=4:
  - Enable with TL=0.
  - After 12 cycles TL=3.
  - Disable for 5 cycles, re-enable: next increment arrives after the remaining prescale count, not a fresh 4.
- Bus edge cases:
  - Write SYSTICK -> value unchanged.
  - Read BASE+0x10 -> 0.
  - TL write coincident with tick -> TL equals written value, not value+1.
  - Overflow with IE=0 -> TL reloads, IRQ stays 0.
